// File: rtl/ad9866_spi_arbiter.sv
// ad9866_spi_arbiter
// Shares the single AD9866 SPI transaction engine between NREQ register-access
// requesters (RX gain, TX gain, host access, filter/cal sequencer). Requests are
// served round-robin once the power-up init program has finished. For each
// grant the arbiter:
//   - builds the 16-bit instruction word,
//   - hands it to the SPI shifter,
//   - waits for the response, bounded by a watchdog,
//   - returns a registered ack/rdata to the winner,
//   - enforces an idle gap before the next grant.
//
// Optional build macro: AD9866_ARB_PRIO0_EN
//   Defined:   requester 0 has strict priority and does not move the RR pointer.
//   Undefined: requester 0 takes part in plain round-robin with the others.
//
// Ports:
//   clk, reset         system clock, asynchronous active-high reset
//   init_done          grants are held off while low
//   req/req_rd         per-requester request level and read(1)/write(0) flag
//   req_addr           5 bits per requester, requester i at [5i+4:5i]
//   req_wdata          8 bits per requester, requester i at [8i+7:8i]
//   ack                one-cycle completion pulse to the granted requester
//   ack_err/rdata      valid with ack: watchdog error flag, readback byte
//   grant_id           index of the current/last granted requester
//   busy               high whenever the arbiter is not IDLE
//   cmd_valid/ready    instruction handshake towards the SPI engine
//   cmd_word           {rd, 2'b00, addr, wdata}, wdata zeroed for reads
//   rsp_valid/rsp_data end-of-transaction pulse and shifted-in byte
module ad9866_spi_arbiter #(
  parameter int NREQ           = 4,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      init_done,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           req_rd,
  input  logic [NREQ*5-1:0]         req_addr,
  input  logic [NREQ*8-1:0]         req_wdata,
  output logic [NREQ-1:0]           ack,
  output logic                      ack_err,
  output logic [7:0]                rdata,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy,
  output logic                      cmd_valid,
  input  logic                      cmd_ready,
  output logic [15:0]               cmd_word,
  input  logic                      rsp_valid,
  input  logic [7:0]                rsp_data
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RSP,
    GAP
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [IDW-1:0]   rr_ptr;
  logic [15:0]      to_cnt;
  logic [7:0]       gap_cnt;

  logic             win_found;
  logic [IDW-1:0]   win_idx;
  logic [IDW-1:0]   win_ptr;
  logic             win_rd;
  logic [4:0]       win_addr;
  logic [7:0]       win_wdata;

  logic             grant_fire;
  logic             to_expire;
  logic             gap_done;

  // Round-robin pick: scan from the pointer upward with wrap-around. The
  // loop runs from the farthest offset down so the nearest request wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(rr_ptr) + k) % NREQ]) begin
        win_found = 1'b1;
        win_idx   = IDW'((int'(rr_ptr) + k) % NREQ);
      end
    end
    win_ptr = IDW'((int'(win_idx) + 1) % NREQ);
`ifdef AD9866_ARB_PRIO0_EN
    // Latency-critical gain path bypasses the rotation entirely. When req[0]
    // is low the scan above can never land on 0, so the others rotate alone.
    if (req[0]) begin
      win_found = 1'b1;
      win_idx   = '0;
      win_ptr   = rr_ptr;
    end
`endif
  end

  // Winner's request fields; only sampled on the grant edge.
  always_comb begin
    win_rd    = req_rd[win_idx];
    win_addr  = req_addr[int'(win_idx) * 5 +: 5];
    win_wdata = req_wdata[int'(win_idx) * 8 +: 8];
  end

  assign grant_fire = (state == IDLE) && init_done && win_found;
  // Counter is cleared on the handshake edge, so it reaches TIMEOUT_CYCLES-1
  // on the TIMEOUT_CYCLES-th WAIT_RSP edge.
  assign to_expire  = (to_cnt == 16'(TIMEOUT_CYCLES - 1));
  // GAP lasts GAP_CYCLES+1 cycles (one cycle when GAP_CYCLES is 0), which
  // gives 4+GAP_CYCLES grant-to-grant for a ready engine with 1-cycle response.
  assign gap_done   = (gap_cnt == 8'(GAP_CYCLES));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. A response arriving together with watchdog expiry is
  // treated as a normal completion.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (grant_fire) state_nxt = ISSUE;
      ISSUE:    if (cmd_ready) state_nxt = WAIT_RSP;
      WAIT_RSP: if (rsp_valid || to_expire) state_nxt = GAP;
      GAP:      if (gap_done) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Outputs decoded straight from the state so cmd_valid drops the moment
  // reset asserts.
  always_comb begin
    cmd_valid = (state == ISSUE);
    busy      = (state != IDLE);
  end

  // Grant bookkeeping, counters and the registered completion outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack      <= '0;
      ack_err  <= 1'b0;
      rdata    <= 8'h00;
      grant_id <= '0;
      rr_ptr   <= '0;
      cmd_word <= 16'h0000;
      to_cnt   <= '0;
      gap_cnt  <= '0;
    end else begin
      ack     <= '0;
      ack_err <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_fire) begin
            grant_id <= win_idx;
            rr_ptr   <= win_ptr;
            cmd_word <= {win_rd, 2'b00, win_addr, (win_rd ? 8'h00 : win_wdata)};
          end
        end
        ISSUE: begin
          if (cmd_ready) to_cnt <= '0;
        end
        WAIT_RSP: begin
          if (rsp_valid) begin
            ack[grant_id] <= 1'b1;
            rdata         <= cmd_word[15] ? rsp_data : 8'h00;
            gap_cnt       <= '0;
          end else if (to_expire) begin
            ack[grant_id] <= 1'b1;
            ack_err       <= 1'b1;
            rdata         <= 8'h00;
            gap_cnt       <= '0;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
